// File: rtl/nic_injector_pkg.sv
// Mesh coordinate and flit field layout shared by NIC inject/eject logic.
// Flit, MSB to LSB: pkt_id, seq[1:0], last, src, dst, data.
`ifndef NIC_GLOBALS_SVH
`define NIC_GLOBALS_SVH
`define NUM_PORT 5
`define DST_WIDTH 4
`define X_COORD 1:0
`define Y_COORD 3:2
`define FLIT_SEQ_WIDTH 2
`define FLIT_DATA_LSB 0
`define FLIT_DST_LSB(DW) (DW)
`define FLIT_SRC_LSB(DW) ((DW) + `DST_WIDTH)
`define FLIT_LAST_BIT(DW) ((DW) + 2 * `DST_WIDTH)
`define FLIT_SEQ_LSB(DW) ((DW) + 2 * `DST_WIDTH + 1)
`define FLIT_ID_LSB(DW) ((DW) + 2 * `DST_WIDTH + 3)
`define FLIT_WIDTH(IW, DW) ((IW) + 3 + 2 * `DST_WIDTH + (DW))
`endif

package nic_injector_pkg;

    localparam int SEQ_W   = `FLIT_SEQ_WIDTH;
    localparam int COORD_W = `DST_WIDTH / 2;

    function automatic logic [SEQ_W-1:0] clamp_len(
        input logic [SEQ_W-1:0] len,
        input int               max_flits
    );
        if (int'(len) > max_flits - 1)
            return SEQ_W'(max_flits - 1);
        return len;
    endfunction

    function automatic logic [`DST_WIDTH-1:0] pack_coord(
        input int x,
        input int y
    );
        logic [`DST_WIDTH-1:0] c;
        c = '0;
        c[`X_COORD] = x[COORD_W-1:0];
        c[`Y_COORD] = y[COORD_W-1:0];
        return c;
    endfunction

endpackage

// File: rtl/nic_req_fifo.sv
// Synchronous request FIFO; exposes head and head+1 so the
// injector can chain packets without a bubble.
module nic_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [WIDTH-1:0] o_next,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_multi
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_next_ptr;

    // Full blocks a push even when the same edge pops.
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign w_next_ptr = r_rd_ptr + 1'b1;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_multi = (r_count > (AW+1)'(1));
    assign o_head  = r_mem[r_rd_ptr];
    assign o_next  = r_mem[w_next_ptr];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nic_injector.sv
// BLESS mesh NIC transmit side: queues core packet requests and injects
// flits on granted router slots. Optional: NIC_STARVE_DETECT_EN.
module nic_injector
    import nic_injector_pkg::*;
#(
    parameter int CORD_X        = 1,
    parameter int CORD_Y        = 1,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_FLITS     = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int ID_WIDTH      = 4,
    parameter int STARVE_THRESH = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [`DST_WIDTH-1:0]             req_dst,
    input  logic [1:0]                        req_len,
    input  logic [MAX_FLITS*DATA_WIDTH-1:0]   req_data,
    input  logic                              inj_slot,
    output logic                              flit_valid,
    output logic [`FLIT_WIDTH(ID_WIDTH, DATA_WIDTH)-1:0] flit_out,
    output logic                              pkt_sent,
`ifdef NIC_STARVE_DETECT_EN
    output logic                              starve,
`endif
    output logic                              busy
);

    localparam int FW    = `FLIT_WIDTH(ID_WIDTH, DATA_WIDTH);
    localparam int PW    = MAX_FLITS * DATA_WIDTH;
    localparam int REQ_W = `DST_WIDTH + SEQ_W + PW;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [`DST_WIDTH-1:0] SRC = pack_coord(CORD_X, CORD_Y);

    logic [0:0]            r_state;
    logic [`DST_WIDTH-1:0] r_dst;
    logic [SEQ_W-1:0]      r_len;
    logic [PW-1:0]         r_data;
    logic [SEQ_W-1:0]      r_seq;
    logic [ID_WIDTH-1:0]   r_pkt_id;
    logic                  r_flit_valid;
    logic [FW-1:0]         r_flit;
    logic                  r_pkt_sent;

    logic [REQ_W-1:0]      w_wdata;
    logic [REQ_W-1:0]      w_head;
    logic [REQ_W-1:0]      w_next;
    logic [REQ_W-1:0]      w_load;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_multi;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_slice;
    logic [FW-1:0]         w_flit;

    assign w_wdata = {req_dst, req_len, req_data};
    assign w_push  = req_valid && !w_full;
    assign w_last  = (r_seq == r_len);
    assign w_pop   = (r_state == S_SEND) && inj_slot && w_last;

    // Chained packets come from head+1 since head is popped this edge.
    assign w_load  = (r_state == S_SEND) ? w_next : w_head;

    nic_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_multi (w_multi)
    );

    always_comb begin
        w_slice = r_data[DATA_WIDTH*int'(r_seq) +: DATA_WIDTH];
    end

    always_comb begin
        w_flit = '0;
        w_flit[`FLIT_DATA_LSB +: DATA_WIDTH]            = w_slice;
        w_flit[`FLIT_DST_LSB(DATA_WIDTH) +: `DST_WIDTH] = r_dst;
        w_flit[`FLIT_SRC_LSB(DATA_WIDTH) +: `DST_WIDTH] = SRC;
        w_flit[`FLIT_LAST_BIT(DATA_WIDTH)]              = w_last;
        w_flit[`FLIT_SEQ_LSB(DATA_WIDTH) +: SEQ_W]      = r_seq;
        w_flit[`FLIT_ID_LSB(DATA_WIDTH) +: ID_WIDTH]    = r_pkt_id;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_dst        <= '0;
            r_len        <= '0;
            r_data       <= '0;
            r_seq        <= '0;
            r_pkt_id     <= '0;
            r_flit_valid <= 1'b0;
            r_flit       <= '0;
            r_pkt_sent   <= 1'b0;
        end else begin
            r_flit_valid <= 1'b0;
            r_pkt_sent   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_dst   <= w_load[REQ_W-1 -: `DST_WIDTH];
                        r_len   <= clamp_len(w_load[PW +: SEQ_W],
                                             MAX_FLITS);
                        r_data  <= w_load[PW-1:0];
                        r_seq   <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (inj_slot) begin
                        r_flit_valid <= 1'b1;
                        r_flit       <= w_flit;
                        if (w_last) begin
                            r_pkt_sent <= 1'b1;
                            r_pkt_id   <= r_pkt_id + 1'b1;
                            r_seq      <= '0;
                            if (w_multi) begin
                                r_dst  <= w_load[REQ_W-1 -: `DST_WIDTH];
                                r_len  <= clamp_len(w_load[PW +: SEQ_W],
                                                    MAX_FLITS);
                                r_data <= w_load[PW-1:0];
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_seq <= r_seq + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = !w_full;
    assign flit_valid = r_flit_valid;
    assign flit_out   = r_flit;
    assign pkt_sent   = r_pkt_sent;
    assign busy       = !w_empty || (r_state != S_IDLE);

`ifdef NIC_STARVE_DETECT_EN
    localparam int SC_W = $clog2(STARVE_THRESH + 1);

    logic [SC_W-1:0] r_starve_cnt;

    // Saturates so a long stall cannot wrap back below threshold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if ((r_state == S_SEND) && !inj_slot) begin
            if (r_starve_cnt < SC_W'(STARVE_THRESH))
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    assign starve = (r_starve_cnt >= SC_W'(STARVE_THRESH));
`else
    logic w_unused_thresh;
    assign w_unused_thresh = (STARVE_THRESH != 0);
`endif

endmodule

// File: tb/tb_nic_injector.sv
// Directed bench for nic_injector with default parameters.
// Build with NIC_STARVE_DETECT_EN to also exercise starvation detect.
`timescale 1ns/1ps
module tb_nic_injector;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_dst = '0;
    logic [1:0]   req_len = '0;
    logic [127:0] req_data = '0;
    logic         inj_slot = 1'b0;
    logic         flit_valid;
    logic [46:0]  flit_out;
    logic         pkt_sent;
    logic         busy;
`ifdef NIC_STARVE_DETECT_EN
    logic         starve;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    nic_injector dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dst    (req_dst),
        .req_len    (req_len),
        .req_data   (req_data),
        .inj_slot   (inj_slot),
        .flit_valid (flit_valid),
        .flit_out   (flit_out),
        .pkt_sent   (pkt_sent),
`ifdef NIC_STARVE_DETECT_EN
        .starve     (starve),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // src is (x=1,y=1) -> {y,x} = 4'b0101
    function automatic logic [46:0] exp_flit(
        input int          id,
        input int          seq,
        input logic        last,
        input logic [3:0]  dst,
        input logic [31:0] data
    );
        logic [3:0] id4;
        logic [1:0] s2;
        id4 = id[3:0];
        s2  = seq[1:0];
        return {id4, s2, last, 4'b0101, dst, data};
    endfunction

    logic [31:0] words [4];
    logic [3:0]  dsts  [4];
    logic [31:0] dats  [4];
    int          pat   [7];
    int          seq;
    logic [3:0]  id_f;

    initial begin
        // reset state
        tick;
        tick;
        check("rst_valid", 64'(flit_valid), 64'd0);
        check("rst_flit", 64'(flit_out), 64'd0);
        check("rst_sent", 64'(pkt_sent), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd1);
        reset = 1'b1;

        // single 1-flit packet to (3,2)
        req_dst   = 4'b1011;
        req_len   = 2'd0;
        req_data  = {96'd0, 32'hA5A5_A5A5};
        inj_slot  = 1'b1;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        check("t1_lat1", 64'(flit_valid), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        tick;
        check("t1_lat2", 64'(flit_valid), 64'd0);
        tick;
        check("t1_valid", 64'(flit_valid), 64'd1);
        check("t1_flit", 64'(flit_out),
              64'(exp_flit(0, 0, 1'b1, 4'b1011, 32'hA5A5_A5A5)));
        check("t1_sent", 64'(pkt_sent), 64'd1);
        tick;
        check("t1_idle_v", 64'(flit_valid), 64'd0);
        check("t1_idle_s", 64'(pkt_sent), 64'd0);
        check("t1_idle_b", 64'(busy), 64'd0);

        // 4-flit packet gated by slot pattern
        words[0] = 32'h1111_0000;
        words[1] = 32'h2222_0001;
        words[2] = 32'h3333_0002;
        words[3] = 32'h4444_0003;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        inj_slot  = 1'b0;
        req_dst   = 4'h6;
        req_len   = 2'd3;
        req_data  = {words[3], words[2], words[1], words[0]};
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        seq = 0;
        for (int i = 0; i < 7; i++) begin
            inj_slot = pat[i][0];
            tick;
            check("t2_valid", 64'(flit_valid), 64'(pat[i][0]));
            check("t2_sent", 64'(pkt_sent),
                  64'(pat[i] == 1 && seq == 3));
            if (pat[i] == 1) begin
                check("t2_flit", 64'(flit_out),
                      64'(exp_flit(1, seq, seq == 3, 4'h6, words[seq])));
                seq++;
            end
        end
        inj_slot = 1'b0;
        tick;
        check("t2_done", 64'(busy), 64'd0);

        // FIFO fill with slots withheld, then back-to-back drain
        reset = 1'b0;
        tick;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dsts[i] = 4'(i + 8);
            dats[i] = 32'hC000_0000 + 32'(i);
        end
        req_len   = 2'd0;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_dst  = dsts[i];
            req_data = {96'd0, dats[i]};
            tick;
            check("t3_ready", 64'(req_ready), 64'(i < 3));
        end
        req_dst  = 4'hE;
        req_data = {96'd0, 32'hDEAD_BEEF};
        tick;
        check("t3_full", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        inj_slot  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t3_valid", 64'(flit_valid), 64'd1);
            check("t3_flit", 64'(flit_out),
                  64'(exp_flit(i, 0, 1'b1, dsts[i], dats[i])));
            check("t3_sent", 64'(pkt_sent), 64'd1);
        end
        tick;
        check("t3_no5th", 64'(flit_valid), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);

        // reset in the middle of a 3-flit packet
        req_dst   = 4'h3;
        req_len   = 2'd2;
        req_data  = {32'd0, words[2], words[1], words[0]};
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        tick;
        check("t4_seq1", 64'(flit_out),
              64'(exp_flit(4, 1, 1'b0, 4'h3, words[1])));
        reset = 1'b0;
        tick;
        reset = 1'b1;
        check("t4_valid", 64'(flit_valid), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_ready", 64'(req_ready), 64'd1);
        tick;
        check("t4_quiet", 64'(flit_valid), 64'd0);
        req_dst   = 4'hF;
        req_len   = 2'd0;
        req_data  = {96'd0, 32'h0000_0077};
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        check("t4_restart", 64'(flit_out),
              64'(exp_flit(0, 0, 1'b1, 4'hF, 32'h0000_0077)));

        // pkt_id wrap over 17 packets; dst 5 is the local node
        reset = 1'b0;
        tick;
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            req_dst   = 4'(i);
            req_data  = {96'd0, 32'(i)};
            req_valid = 1'b1;
            tick;
            req_valid = 1'b0;
            tick;
            tick;
            id_f = flit_out[46:43];
            check("t5_valid", 64'(flit_valid), 64'd1);
            check("t5_id", 64'(id_f), 64'(i % 16));
            check("t5_dst", 64'(flit_out[35:32]), 64'(i % 16));
        end

`ifdef NIC_STARVE_DETECT_EN
        // starvation: 16 stalled SEND cycles then one grant
        tick;
        inj_slot  = 1'b0;
        req_dst   = 4'h2;
        req_data  = {96'd0, 32'h5555_AAAA};
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        check("t6_start", 64'(starve), 64'd0);
        for (int k = 1; k <= 16; k++) begin
            tick;
            check("t6_starve", 64'(starve), 64'(k >= 16));
        end
        inj_slot = 1'b1;
        tick;
        check("t6_clear", 64'(starve), 64'd0);
        check("t6_flit", 64'(flit_out),
              64'(exp_flit(1, 0, 1'b1, 4'h2, 32'h5555_AAAA)));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nic_injector.md
Name: nic_injector

Overview:
- Transmit-side network interface for a BLESS mesh node.
- Accepts packet requests from the local core and builds header-tagged flits carrying the destination coordinate field.
- The router's route computation consumes that destination field at each hop.
- Flits are injected into the local router only on cycles where the router grants a free injection slot, since bufferless routers inject only when an output port is unclaimed.

Parameters:
- CORD_X, default 1: this node's X coordinate, written into the src field.
- CORD_Y, default 1: this node's Y coordinate, written into the src field.
- DATA_WIDTH, default 32: payload bits per flit.
- MAX_FLITS, default 4: maximum flits per packet; power of two, at most 4.
- FIFO_DEPTH, default 4: packet-request FIFO entries; power of two, at least 2.
- ID_WIDTH, default 4: packet-ID counter width.
- STARVE_THRESH, default 16: starvation threshold, used only with the optional feature.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  core presents a packet request.
- req_ready  out  1  request FIFO not full.
- req_dst  in  `DST_WIDTH  destination; X in [`X_COORD], Y in [`Y_COORD].
- req_len  in  2  flit count minus 1.
- req_data  in  MAX_FLITS*DATA_WIDTH  payload; flit k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- inj_slot  in  1  router grants an injection slot for the next cycle.
- flit_valid  out  1  flit_out holds a flit this cycle.
- flit_out  out  FLIT_WIDTH  packed flit {pkt_id, seq[1:0], last, src, dst, data}.
- pkt_sent  out  1  one-cycle pulse when the last flit of a packet is emitted.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- FLIT_WIDTH = ID_WIDTH + 3 + 2*`DST_WIDTH + DATA_WIDTH.
- src = {CORD_Y, CORD_X}, packed in the same bit positions as dst.
- Reset (reset==0 at a clock edge):
  - FIFO empties; FSM goes to IDLE; seq and pkt_id clear to 0.
  - flit_valid=0, flit_out=0, pkt_sent=0, busy=0, req_ready=1.
  - Reset mid-packet drops the partial packet; no completion of an in-flight packet.
- Request FIFO:
  - Push when req_valid && req_ready.
  - req_ready = !full; it depends on registered state only.
  - When the FIFO is full, a same-cycle pop does not admit a push.
  - Stored fields: dst, len, data.
- FSM states: IDLE, SEND.
  - IDLE: if the FIFO is non-empty, load the head into the working register, set seq=0, go to SEND. A request pushed at edge N is loaded at edge N+1.
  - SEND: at each edge where inj_slot==1, register a flit.
    - Fields: dst, src, pkt_id, seq, last=(seq==len), data=slice[seq].
    - flit_valid=1 on the following cycle.
    - If not last: seq increments.
    - If last: pop the FIFO, pkt_id increments (wraps at 2^ID_WIDTH), pkt_sent pulses with that flit.
    - After the last flit, if the FIFO still holds a request, load it in the same edge and stay in SEND (back-to-back, no bubble); otherwise go to IDLE.
  - At each edge where inj_slot==0, flit_valid=0 next cycle and seq holds.
- Latency: first flit appears no earlier than 2 cycles after request acceptance. With inj_slot held high, flits emit one per cycle.
- inj_slot in IDLE is ignored.
- dst equal to the local coordinate is injected normally; the router ejects it.
- Out-of-range len (len > MAX_FLITS-1) is clamped to MAX_FLITS-1.

Optional Feature:
- NIC_STARVE_DETECT_EN defined:
  - Adds output starve (1 bit, reset 0) and a saturating counter.
  - Counter counts consecutive SEND cycles with inj_slot==0 and clears on any granted slot or on leaving SEND.
  - starve=1 while counter >= STARVE_THRESH.
- Undefined: no counter, no starve port.

Decomposition:
- Shared package/global header: `DST_WIDTH, `X_COORD, `Y_COORD, `NUM_PORT (existing), plus new flit field offsets/widths and FLIT_WIDTH macros.
- Ejection-side logic uses those same offsets.
- One sub-module: nic_req_fifo, a synchronous parameterised FIFO with full/empty flags.

Test Plan:
- Single 1-flit packet, dst=(3,2), data=0xA5A5A5A5, inj_slot=1 → one flit 2 cycles after acceptance; last=1, seq=0, src=(1,1), pkt_id=0, pkt_sent pulse.
- 4-flit packet, inj_slot pattern 1,0,0,1,1,0,1 → flits seq 0..3 appear only after granted slots, data slices in order, pkt_sent only with seq 3.
- Four requests back-to-back while inj_slot=0 → req_ready drops after the 4th. A 5th req_valid is not accepted. With slots enabled, packets emit with pkt_id 0,1,2,3 and no idle bubble between packets.
- Reset asserted after seq 1 of a 3-flit packet → next cycle flit_valid=0, busy=0, req_ready=1; the next packet starts with pkt_id=0, seq=0.
- pkt_id wrap: 17 packets with ID_WIDTH=4 → 17th carries pkt_id=0.
- With NIC_STARVE_DETECT_EN: 16 cycles SEND with inj_slot=0 → starve=1 on cycle 16; one granted slot → starve=0 next cycle.
